// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: synchronous FIFO controller driving an external 1-cycle-latency memory
// Ports:
//   clk, rstn (async active-low)
//   push/push_data             : write request and word
//   pop -> pop_valid/pop_data  : read request, data one cycle later
//   full/empty/almost_full     : registered status flags
//   count                      : stored words, 0..DEPTH
//   mem_write_en/addr/data     : memory write port
//   mem_read_en/addr, mem_read_data : memory read port
//   overflow/underflow         : sticky error flags, present when SYNC_FIFO_ERR_FLAGS_EN is defined
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  mem_write_en,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_read_en,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  input  logic [DATA_WIDTH-1:0] mem_read_data
);
  localparam int CW = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  logic [CW-1:0] wr_ptr_q, rd_ptr_q, count_q, count_d;
  logic full_q, empty_q, af_q, pop_valid_q;
  logic push_ok, pop_ok;
  // memory strobes are gated by rstn so nothing reaches the memory while reset is held
  assign push_ok = push & ~full_q & rstn;
  assign pop_ok = pop & ~empty_q & rstn;
  assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  assign mem_write_en = push_ok;
  assign mem_write_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign mem_write_data = push_data;
  assign mem_read_en = pop_ok;
  assign mem_read_addr = rd_ptr_q[ADDR_WIDTH-1:0];
  assign pop_data = mem_read_data;
  assign pop_valid = pop_valid_q;
  assign full = full_q;
  assign empty = empty_q;
  assign almost_full = af_q;
  assign count = count_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
      af_q <= 1'b0;
      pop_valid_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + CW'(push_ok);
      rd_ptr_q <= rd_ptr_q + CW'(pop_ok);
      count_q <= count_d;
      full_q <= count_d == CW'(DEPTH);
      empty_q <= count_d == '0;
      af_q <= count_d >= CW'(DEPTH - AF_MARGIN);
      pop_valid_q <= pop_ok;
    end
  end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;
  assign overflow = overflow_q;
  assign underflow = underflow_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_q | (push & full_q);
      underflow_q <= underflow_q | (pop & empty_q);
    end
  end
`endif
endmodule
